// File: rtl/frv_gpr_wport_arbiter_if.sv
// Write-port bundle: writeback and long-unit requests in,
// register file write and pending mask out.
interface frv_gpr_wport_arbiter_if #(
  parameter int XLEN = 32
);
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_wdata;
  logic            wb_ready;
  logic            lu_valid;
  logic [4:0]      lu_rd;
  logic [XLEN-1:0] lu_wdata;
  logic            lu_ready;
  logic            gpr_wen;
  logic [4:0]      gpr_rd;
  logic [XLEN-1:0] gpr_wdata;
  logic [31:0]     lu_pend_mask;

  modport master (
    output wb_valid, wb_rd, wb_wdata,
    output lu_valid, lu_rd, lu_wdata,
    input  wb_ready, lu_ready,
    input  gpr_wen, gpr_rd, gpr_wdata,
    input  lu_pend_mask
  );

  modport slave (
    input  wb_valid, wb_rd, wb_wdata,
    input  lu_valid, lu_rd, lu_wdata,
    output wb_ready, lu_ready,
    output gpr_wen, gpr_rd, gpr_wdata,
    output lu_pend_mask
  );
endinterface

// File: rtl/frv_gpr_wport_arbiter.sv
// GPR write-port arbiter: writeback vs a 2-entry long-unit FIFO,
// with a starvation override and a per-register pending mask.
module frv_gpr_wport_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic                      g_clk,
  input logic                      g_reset,
  frv_gpr_wport_arbiter_if.slave   port
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [4:0]      rd_q   [2];
  logic [XLEN-1:0] data_q [2];
  logic [4:0]      rd_d   [2];
  logic [XLEN-1:0] data_d [2];
  logic            wptr_q, wptr_d;
  logic            rptr_q, rptr_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [3:0]      starve_q, starve_d;

  logic nonempty;
  logic force_lu;
  logic lu_win;
  logic wb_win;
  logic push;
  logic pop;
  logic [31:0] mask;

  assign nonempty = (cnt_q != 2'd0);
  assign force_lu = nonempty && (starve_q == LIMIT);

  assign lu_win = !g_reset && nonempty
                  && (force_lu || !port.wb_valid);
  assign wb_win = !g_reset && !force_lu && port.wb_valid;

  assign port.wb_ready = !g_reset && !force_lu;
  assign port.lu_ready = !g_reset && (cnt_q != 2'd2);

  assign push = port.lu_valid && port.lu_ready;
  assign pop  = lu_win;

  always_comb begin
    port.gpr_rd    = '0;
    port.gpr_wdata = '0;
    unique case (1'b1)
      lu_win: begin
        port.gpr_rd    = rd_q[rptr_q];
        port.gpr_wdata = data_q[rptr_q];
      end
      wb_win: begin
        port.gpr_rd    = port.wb_rd;
        port.gpr_wdata = port.wb_wdata;
      end
      default: ;
    endcase
  end

  assign port.gpr_wen = (lu_win || wb_win)
                        && (port.gpr_rd != 5'd0);

  // Head counts as pending even while being popped.
  always_comb begin
    mask = '0;
    if (cnt_q != 2'd0) mask[rd_q[rptr_q]]  = 1'b1;
    if (cnt_q == 2'd2) mask[rd_q[!rptr_q]] = 1'b1;
    mask[0] = 1'b0;
  end

  assign port.lu_pend_mask = g_reset ? 32'd0 : mask;

  always_comb begin
    rd_d   = rd_q;
    data_d = data_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      rd_d[wptr_q]   = port.lu_rd;
      data_d[wptr_q] = port.lu_wdata;
      wptr_d         = !wptr_q;
    end
    if (pop) rptr_d = !rptr_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (!nonempty || pop)
      starve_d = '0;
    else if (starve_q < LIMIT)
      starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      rd_q     <= '{default: '0};
      data_q   <= '{default: '0};
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= 2'd0;
      starve_q <= 4'd0;
    end else begin
      rd_q     <= rd_d;
      data_q   <= data_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_frv_gpr_wport_arbiter.sv
// Directed bench for the GPR write-port arbiter.
module tb_frv_gpr_wport_arbiter;

  logic g_clk;
  logic g_reset;
  int   n_chk;
  int   n_fail;

  frv_gpr_wport_arbiter_if #(.XLEN(32)) bus ();

  frv_gpr_wport_arbiter #(
    .XLEN(32),
    .STARVE_LIMIT(4)
  ) dut (
    .g_clk   (g_clk),
    .g_reset (g_reset),
    .port    (bus.slave)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic mid();
    @(negedge g_clk);
  endtask

  task automatic lu(input logic v, input logic [4:0] rd,
                    input logic [31:0] d);
    bus.lu_valid = v;
    bus.lu_rd    = rd;
    bus.lu_wdata = d;
  endtask

  task automatic wb(input logic v, input logic [4:0] rd,
                    input logic [31:0] d);
    bus.wb_valid = v;
    bus.wb_rd    = rd;
    bus.wb_wdata = d;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    g_reset = 1'b1;
    wb(1'b1, 5'd5, 32'h55);
    lu(1'b1, 5'd9, 32'h99);
    #1;

    for (int i = 0; i < 3; i++) begin
      mid();
      chk("rst_wen", 64'(bus.gpr_wen), 64'd0);
      chk("rst_wbr", 64'(bus.wb_ready), 64'd0);
      chk("rst_lur", 64'(bus.lu_ready), 64'd0);
      chk("rst_mask", 64'(bus.lu_pend_mask), 64'd0);
      chk("rst_rd", 64'(bus.gpr_rd), 64'd0);
      tick();
    end

    g_reset = 1'b0;
    lu(1'b0, 5'd0, 32'h0);
    mid();
    chk("rel_wen", 64'(bus.gpr_wen), 64'd1);
    chk("rel_rd", 64'(bus.gpr_rd), 64'd5);
    chk("rel_data", 64'(bus.gpr_wdata), 64'h55);
    chk("rel_wbr", 64'(bus.wb_ready), 64'd1);
    chk("rel_lur", 64'(bus.lu_ready), 64'd1);
    tick();

    // LU only
    wb(1'b0, 5'd0, 32'h0);
    lu(1'b1, 5'd7, 32'hDEADBEEF);
    mid();
    chk("lu0_wen", 64'(bus.gpr_wen), 64'd0);
    chk("lu0_mask", 64'(bus.lu_pend_mask), 64'd0);
    tick();
    lu(1'b0, 5'd0, 32'h0);
    mid();
    chk("lu1_wen", 64'(bus.gpr_wen), 64'd1);
    chk("lu1_rd", 64'(bus.gpr_rd), 64'd7);
    chk("lu1_data", 64'(bus.gpr_wdata), 64'hDEADBEEF);
    chk("lu1_mask", 64'(bus.lu_pend_mask), 64'h80);
    tick();
    mid();
    chk("lu2_wen", 64'(bus.gpr_wen), 64'd0);
    chk("lu2_rd", 64'(bus.gpr_rd), 64'd0);
    chk("lu2_data", 64'(bus.gpr_wdata), 64'd0);
    chk("lu2_mask", 64'(bus.lu_pend_mask), 64'd0);
    tick();

    // Starvation
    wb(1'b1, 5'd10, 32'hA0);
    lu(1'b1, 5'd3, 32'h33);
    mid();
    chk("st0_wbr", 64'(bus.wb_ready), 64'd1);
    chk("st0_rd", 64'(bus.gpr_rd), 64'd10);
    tick();
    lu(1'b0, 5'd0, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      mid();
      chk("st_wbr", 64'(bus.wb_ready), 64'd1);
      chk("st_rd", 64'(bus.gpr_rd), 64'd10);
      chk("st_mask", 64'(bus.lu_pend_mask), 64'h8);
      tick();
    end
    mid();
    chk("st5_wbr", 64'(bus.wb_ready), 64'd0);
    chk("st5_rd", 64'(bus.gpr_rd), 64'd3);
    chk("st5_data", 64'(bus.gpr_wdata), 64'h33);
    chk("st5_wen", 64'(bus.gpr_wen), 64'd1);
    tick();
    mid();
    chk("st6_wbr", 64'(bus.wb_ready), 64'd1);
    chk("st6_rd", 64'(bus.gpr_rd), 64'd10);
    chk("st6_mask", 64'(bus.lu_pend_mask), 64'd0);
    tick();

    // Full backpressure, in-order drain
    lu(1'b1, 5'd1, 32'h11);
    tick();
    lu(1'b1, 5'd2, 32'h22);
    tick();
    lu(1'b1, 5'd4, 32'h44);
    mid();
    chk("bp2_lur", 64'(bus.lu_ready), 64'd0);
    chk("bp2_mask", 64'(bus.lu_pend_mask), 64'h6);
    chk("bp2_rd", 64'(bus.gpr_rd), 64'd10);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    mid();
    chk("bp3_rd", 64'(bus.gpr_rd), 64'd1);
    chk("bp3_data", 64'(bus.gpr_wdata), 64'h11);
    chk("bp3_lur", 64'(bus.lu_ready), 64'd0);
    tick();
    lu(1'b0, 5'd0, 32'h0);
    mid();
    chk("bp4_rd", 64'(bus.gpr_rd), 64'd2);
    chk("bp4_data", 64'(bus.gpr_wdata), 64'h22);
    chk("bp4_mask", 64'(bus.lu_pend_mask), 64'h4);
    chk("bp4_lur", 64'(bus.lu_ready), 64'd1);
    tick();
    mid();
    chk("bp5_wen", 64'(bus.gpr_wen), 64'd0);
    chk("bp5_mask", 64'(bus.lu_pend_mask), 64'd0);
    tick();

    // rd = 0 from both sources
    lu(1'b1, 5'd0, 32'hAA);
    tick();
    lu(1'b0, 5'd0, 32'h0);
    mid();
    chk("z1_wen", 64'(bus.gpr_wen), 64'd0);
    chk("z1_mask", 64'(bus.lu_pend_mask), 64'd0);
    tick();
    lu(1'b1, 5'd6, 32'h66);
    tick();
    lu(1'b0, 5'd0, 32'h0);
    mid();
    chk("z3_rd", 64'(bus.gpr_rd), 64'd6);
    chk("z3_wen", 64'(bus.gpr_wen), 64'd1);
    tick();
    wb(1'b1, 5'd0, 32'hBB);
    mid();
    chk("zwb_wbr", 64'(bus.wb_ready), 64'd1);
    chk("zwb_wen", 64'(bus.gpr_wen), 64'd0);
    tick();

    // Reset with a full FIFO
    wb(1'b1, 5'd10, 32'hA0);
    lu(1'b1, 5'd12, 32'hC);
    tick();
    lu(1'b1, 5'd13, 32'hD);
    tick();
    lu(1'b0, 5'd0, 32'h0);
    mid();
    chk("mr_lur", 64'(bus.lu_ready), 64'd0);
    chk("mr_mask", 64'(bus.lu_pend_mask), 64'h3000);
    tick();
    g_reset = 1'b1;
    wb(1'b0, 5'd0, 32'h0);
    mid();
    chk("mr_rwen", 64'(bus.gpr_wen), 64'd0);
    chk("mr_rmask", 64'(bus.lu_pend_mask), 64'd0);
    chk("mr_rwbr", 64'(bus.wb_ready), 64'd0);
    tick();
    g_reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      mid();
      chk("mr_wen", 64'(bus.gpr_wen), 64'd0);
      chk("mr_mask0", 64'(bus.lu_pend_mask), 64'd0);
      chk("mr_lur1", 64'(bus.lu_ready), 64'd1);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
